spi_frame_committer: RTL and testbench

Frame-level controller that sits between the SPI byte receiver and the game-board tile RAM. It parses each chip-select-framed SPI transaction into a write-cells or clear-board command and buffers the cell updates. During vertical blanking it commits them to the tile RAM, so the VGA scan never shows a half-applied update. It replaces bare end-of-transaction detection with full sequencing of the memory write port.

---
 rtl/snake_pkg.sv | 36 +++
 rtl/spi_frame_committer_fifo.sv | 54 +++++
 rtl/spi_frame_committer.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_frame_committer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the SPI frame committer and its cell buffer.
package snake_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_COUNT,
    S_X,
    S_Y,
    S_TILE,
    S_WAIT_END,
    S_DROP,
    S_PENDING,
    S_COMMIT,
    S_CLEAR
  } state_e;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_CLEAR = 8'h02;

  localparam int unsigned DEF_GRID_W = 32;
  localparam int unsigned DEF_GRID_H = 24;

  // Raw bytes as received; tile is narrowed to TILE_W only when written to RAM.
  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] tile;
  } cell_t;

  function automatic logic in_grid(input logic [7:0] x, input logic [7:0] y,
                                   input int unsigned gw, input int unsigned gh);
    return ({24'd0, x} < gw) && ({24'd0, y} < gh);
  endfunction

endpackage

// File: rtl/spi_frame_committer_fifo.sv
// Synchronous first-word-fall-through FIFO holding the cell updates of one frame.
module cell_fifo
  import snake_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  cell_t din,
  input  logic  pop,
  input  logic  flush,
  output cell_t dout,
  output logic  full,
  output logic  empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  cell_t          mem_q [DEPTH];
  logic [PW-1:0]  wr_q, rd_q;
  logic [CW-1:0]  cnt_q;
  logic           do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign dout    = mem_q[rd_q];

  // Storage array; no reset needed since occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  // Pointers and occupancy; flush empties the buffer in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (do_pop)  rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/spi_frame_committer.sv
// Parses CS-framed SPI commands, buffers cell updates and commits them to the
// tile RAM only during vertical blanking.
module spi_frame_committer
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W    = DEF_GRID_W,
  parameter int unsigned GRID_H    = DEF_GRID_H,
  parameter int unsigned MAX_CELLS = 8,
  parameter int unsigned TILE_W    = 4,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  input  logic              vblank,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [TILE_W-1:0] mem_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        frame_count
);

  localparam logic [ADDR_W:0] N_CELLS = (ADDR_W + 1)'(GRID_W * GRID_H);

  state_e            state_q, state_d, rx_st;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        x_q, x_d, y_q, y_d;
  logic              bad_q, bad_d;
  logic              clear_q, clear_d;
  logic              rej_q, rej_d;
  logic [ADDR_W:0]   clr_q, clr_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TILE_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        count_q, count_d;

  logic              push, pop, flush, fifo_full, fifo_empty;
  cell_t             push_cell, head;
  logic [ADDR_W-1:0] head_addr;

  assign push_cell = '{x: x_q, y: y_q, tile: rx_byte};
  assign head_addr = ADDR_W'(head.y) * ADDR_W'(GRID_W) + ADDR_W'(head.x);

  cell_fifo #(.DEPTH(MAX_CELLS)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .din   (push_cell),
    .pop   (pop),
    .flush (flush),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame parser, commit/clear sequencer and output next-state logic.
  always_comb begin
    state_d = state_q;
    rx_st   = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    bad_d   = bad_q;
    clear_d = clear_q;
    rej_d   = rej_q;
    clr_d   = clr_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cs && !rej_q) begin
          state_d = S_CMD;
          bad_d   = 1'b0;
          clear_d = 1'b0;
        end
      end
      S_CMD, S_COUNT, S_X, S_Y, S_TILE, S_WAIT_END: begin
        // The byte is consumed first so a cs fall in the same cycle sees the
        // post-byte state when deciding between pending and drop.
        if (rx_valid) begin
          case (state_q)
            S_CMD: begin
              if (rx_byte == CMD_WRITE) rx_st = S_COUNT;
              else if (rx_byte == CMD_CLEAR) begin
                rx_st   = S_WAIT_END;
                clear_d = 1'b1;
              end else rx_st = S_DROP;
            end
            S_COUNT: begin
              if (rx_byte != 8'd0 && {24'd0, rx_byte} <= MAX_CELLS) begin
                cnt_d = rx_byte;
                rx_st = S_X;
              end else rx_st = S_DROP;
            end
            S_X: begin
              x_d   = rx_byte;
              rx_st = S_Y;
            end
            S_Y: begin
              y_d   = rx_byte;
              rx_st = S_TILE;
            end
            S_TILE: begin
              if (in_grid(x_q, y_q, GRID_W, GRID_H)) push = 1'b1;
              else bad_d = 1'b1;
              cnt_d = cnt_q - 8'd1;
              rx_st = (cnt_q == 8'd1) ? S_WAIT_END : S_X;
            end
            default: bad_d = 1'b1;
          endcase
        end
        if (!cs) rx_st = (rx_st == S_WAIT_END && !bad_d) ? S_PENDING : S_DROP;
        state_d = rx_st;
      end
      S_DROP: begin
        flush = 1'b1;
        if (!cs) state_d = S_IDLE;
      end
      S_PENDING: begin
        if (vblank) begin
          state_d = clear_q ? S_CLEAR : S_COMMIT;
          clr_d   = '0;
        end
      end
      S_COMMIT: begin
        if (fifo_empty) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (vblank) begin
          pop     = 1'b1;
          we_d    = 1'b1;
          addr_d  = head_addr;
          wdata_d = TILE_W'(head.tile);
        end
      end
      S_CLEAR: begin
        if (clr_q == N_CELLS) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (vblank) begin
          we_d    = 1'b1;
          addr_d  = clr_q[ADDR_W-1:0];
          wdata_d = '0;
          clr_d   = clr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DROP && state_q != S_DROP) err_d = 1'b1;

    // A transaction seen while busy is remembered until its cs fall, which
    // also keeps it from reaching the parser once the commit finishes.
    if (cs && (state_q inside {S_PENDING, S_COMMIT, S_CLEAR})) rej_d = 1'b1;
    if (rej_q && !cs) begin
      rej_d = 1'b0;
      err_d = 1'b1;
    end

    busy_d  = state_d inside {S_PENDING, S_COMMIT, S_CLEAR};
    count_d = count_q + {7'd0, done_d};
  end

  // All state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      bad_q   <= 1'b0;
      clear_q <= 1'b0;
      rej_q   <= 1'b0;
      clr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bad_q   <= bad_d;
      clear_q <= clear_d;
      rej_q   <= rej_d;
      clr_q   <= clr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_spi_frame_committer.sv
// Directed bench for spi_frame_committer with hand-computed expectations.
module tb_spi_frame_committer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       vblank;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [3:0] mem_wdata;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
  logic [7:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] wa[$];
  logic [3:0] wd[$];
  int         wc[$];
  int         cyc = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         b_w, b_d, b_e;
  logic [7:0] frm[$];

  spi_frame_committer #(
    .GRID_W(32), .GRID_H(24), .MAX_CELLS(8), .TILE_W(4), .ADDR_W(10)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .vblank(vblank), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // Passive log of RAM writes and pulse outputs.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_err)  err_cnt  <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_w = wa.size();
    b_d = done_cnt;
    b_e = err_cnt;
  endtask

  task automatic send_frame();
    tick();
    cs = 1'b1;
    tick();
    for (int i = 0; i < frm.size(); i++) begin
      rx_byte  = frm[i];
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      tick();
    end
    cs = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > b_d) break;
    end
    tick();
  endtask

  task automatic run_bad(input string tag);
    mark();
    send_frame();
    repeat (10) tick();
    chk({tag, "_err"},  err_cnt - b_e, 1);
    chk({tag, "_wr"},   wa.size() - b_w, 0);
    chk({tag, "_done"}, done_cnt - b_d, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    reset = 1'b0; cs = 1'b0; rx_byte = '0; rx_valid = 1'b0; vblank = 1'b0;
    repeat (3) tick();
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_count", frame_count, 0);
    reset = 1'b1;
    tick();

    // Two cells committed immediately: (3,1)->35, (31,23)->767.
    vblank = 1'b1;
    frm = '{8'h01, 8'h02, 8'h03, 8'h01, 8'h05, 8'h1F, 8'h17, 8'h0A};
    mark();
    send_frame();
    wait_done(50);
    chk("w1_nwr", wa.size() - b_w, 2);
    chk("w1_a0", wa[b_w], 35);
    chk("w1_d0", wd[b_w], 5);
    chk("w1_a1", wa[b_w+1], 767);
    chk("w1_d1", wd[b_w+1], 10);
    chk("w1_consec", wc[b_w+1] - wc[b_w], 1);
    chk("w1_done", done_cnt - b_d, 1);
    chk("w1_err", err_cnt - b_e, 0);
    chk("w1_count", frame_count, 1);
    chk("w1_busy", busy, 0);

    // Same frame held pending by vblank low.
    vblank = 1'b0;
    mark();
    send_frame();
    repeat (100) tick();
    chk("w2_busy", busy, 1);
    chk("w2_nowr", wa.size() - b_w, 0);
    vblank = 1'b1;
    wait_done(50);
    chk("w2_nwr", wa.size() - b_w, 2);
    chk("w2_a0", wa[b_w], 35);
    chk("w2_a1", wa[b_w+1], 767);
    chk("w2_count", frame_count, 2);

    // Three cells, vblank interrupted after the first write.
    vblank = 1'b0;
    frm = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h00, 8'h03};
    mark();
    send_frame();
    repeat (5) tick();
    vblank = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_we) break;
    end
    vblank = 1'b0;
    repeat (20) tick();
    chk("w3_part", wa.size() - b_w, 1);
    chk("w3_busy", busy, 1);
    vblank = 1'b1;
    wait_done(50);
    chk("w3_nwr", wa.size() - b_w, 3);
    chk("w3_a0", wa[b_w], 0);
    chk("w3_a1", wa[b_w+1], 1);
    chk("w3_a2", wa[b_w+2], 2);
    chk("w3_d2", wd[b_w+2], 3);
    chk("w3_count", frame_count, 3);

    // Malformed frames.
    frm = '{8'h01, 8'h02, 8'h03, 8'h01};
    run_bad("trunc");
    frm = '{8'h01, 8'h09, 8'h00, 8'h00, 8'h00};
    run_bad("n9");
    frm = '{8'h01, 8'h01, 8'h20, 8'h00, 8'h05};
    run_bad("x32");
    frm = '{8'h07};
    run_bad("cmd7");
    frm = '{8'h01, 8'h01, 8'h03, 8'h01, 8'h05, 8'hAA};
    run_bad("trail");
    chk("bad_count", frame_count, 3);

    // A good frame afterwards sees no leftover cells: (5,2)->69.
    frm = '{8'h01, 8'h01, 8'h05, 8'h02, 8'h07};
    mark();
    send_frame();
    wait_done(50);
    chk("w4_nwr", wa.size() - b_w, 1);
    chk("w4_a0", wa[b_w], 69);
    chk("w4_d0", wd[b_w], 7);
    chk("w4_count", frame_count, 4);

    // Clear sweep with a rejected frame arriving mid-clear.
    frm = '{8'h02};
    mark();
    send_frame();
    frm = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h01};
    send_frame();
    wait_done(2000);
    repeat (20) tick();
    chk("clr_nwr", wa.size() - b_w, 768);
    begin
      int bad_entries = 0;
      for (int i = 0; i < 768; i++)
        if (wa[b_w+i] !== 10'(i) || wd[b_w+i] !== 4'd0) bad_entries++;
      chk("clr_sweep", bad_entries, 0);
    end
    chk("clr_err", err_cnt - b_e, 1);
    chk("clr_done", done_cnt - b_d, 1);
    chk("clr_count", frame_count, 5);

    // Reset mid-commit.
    vblank = 1'b0;
    frm = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h02, 8'h02, 8'h00, 8'h03};
    mark();
    send_frame();
    repeat (3) tick();
    vblank = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_we) break;
    end
    reset = 1'b0;
    #1;
    chk("rm_we", mem_we, 0);
    chk("rm_addr", mem_addr, 0);
    chk("rm_busy", busy, 0);
    chk("rm_count", frame_count, 0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    chk("rm_nowr", wa.size() - b_w, 1);
    frm = '{8'h01, 8'h01, 8'h03, 8'h01, 8'h05};
    mark();
    send_frame();
    wait_done(50);
    chk("rm2_nwr", wa.size() - b_w, 1);
    chk("rm2_a0", wa[b_w], 35);
    chk("rm2_d0", wd[b_w], 5);
    chk("rm2_count", frame_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
